// File: rtl/reservation_alu3_issue.sv
// ALU3 issue stage: picks the lowest-index ready reservation entry, captures it
// into the ALU input register and owns the in-order EX execution pointer.
module reservation_alu3_issue #(
    parameter int unsigned P_ENTRY_N = 4
)(
    input  logic                      iCLOCK,
    input  logic                      inRESET,
    input  logic                      iREMOVE_VALID,
    input  logic [P_ENTRY_N-1:0]      iENTRY_MATCHING,
    input  logic [5*P_ENTRY_N-1:0]    iENTRY_CMD,
    input  logic [P_ENTRY_N-1:0]      iENTRY_SYS_LDST,
    input  logic [P_ENTRY_N-1:0]      iENTRY_LDST,
    input  logic [P_ENTRY_N-1:0]      iENTRY_SOURCE0_SYSREG,
    input  logic [32*P_ENTRY_N-1:0]   iENTRY_SOURCE0,
    input  logic [P_ENTRY_N-1:0]      iENTRY_SOURCE1_SYSREG,
    input  logic [32*P_ENTRY_N-1:0]   iENTRY_SOURCE1,
    input  logic [6*P_ENTRY_N-1:0]    iENTRY_DESTINATION_REGNAME,
    input  logic [P_ENTRY_N-1:0]      iENTRY_DESTINATION_SYSREG,
    input  logic [6*P_ENTRY_N-1:0]    iENTRY_COMMIT_TAG,
    input  logic [32*P_ENTRY_N-1:0]   iENTRY_PC,
    output logic [P_ENTRY_N-1:0]      oEXOUT_VALID,
    output logic [3:0]                oEX_EXECUTION_POINTER,
    input  logic                      iALU_LOCK,
    output logic                      oALU_VALID,
    output logic [4:0]                oALU_CMD,
    output logic                      oALU_SYS_LDST,
    output logic                      oALU_LDST,
    output logic                      oALU_SOURCE0_SYSREG,
    output logic [31:0]               oALU_SOURCE0,
    output logic                      oALU_SOURCE1_SYSREG,
    output logic [31:0]               oALU_SOURCE1,
    output logic [5:0]                oALU_DESTINATION_REGNAME,
    output logic                      oALU_DESTINATION_SYSREG,
    output logic [5:0]                oALU_COMMIT_TAG,
    output logic [31:0]               oALU_PC
);
    localparam int unsigned L_CMD_W  = 5;
    localparam int unsigned L_DATA_W = 32;
    localparam int unsigned L_REG_W  = 6;
    localparam int unsigned L_PTR_W  = 4;

    logic                 w_found;
    logic [P_ENTRY_N-1:0] w_onehot;
    logic [L_CMD_W-1:0]   w_cmd;
    logic                 w_sys_ldst, w_ldst, w_s0_sys, w_s1_sys, w_dst_sys;
    logic [L_DATA_W-1:0]  w_s0, w_s1, w_pc;
    logic [L_REG_W-1:0]   w_dst, w_tag;
    logic                 w_accept, w_issue;

    logic                 r_valid;
    logic [L_CMD_W-1:0]   r_cmd;
    logic                 r_sys_ldst, r_ldst, r_s0_sys, r_s1_sys, r_dst_sys;
    logic [L_DATA_W-1:0]  r_s0, r_s1, r_pc;
    logic [L_REG_W-1:0]   r_dst, r_tag;
    logic [L_PTR_W-1:0]   r_ptr;

    // Fixed-priority select: lowest ready index wins, its fields are muxed out.
    always_comb begin
        w_found    = 1'b0;
        w_onehot   = '0;
        w_cmd      = '0;
        w_sys_ldst = 1'b0;
        w_ldst     = 1'b0;
        w_s0_sys   = 1'b0;
        w_s1_sys   = 1'b0;
        w_dst_sys  = 1'b0;
        w_s0       = '0;
        w_s1       = '0;
        w_pc       = '0;
        w_dst      = '0;
        w_tag      = '0;
        for (int k = 0; k < P_ENTRY_N; k++) begin
            if (iENTRY_MATCHING[k] && !w_found) begin
                w_found     = 1'b1;
                w_onehot[k] = 1'b1;
                w_cmd       = iENTRY_CMD[k*L_CMD_W +: L_CMD_W];
                w_sys_ldst  = iENTRY_SYS_LDST[k];
                w_ldst      = iENTRY_LDST[k];
                w_s0_sys    = iENTRY_SOURCE0_SYSREG[k];
                w_s1_sys    = iENTRY_SOURCE1_SYSREG[k];
                w_dst_sys   = iENTRY_DESTINATION_SYSREG[k];
                w_s0        = iENTRY_SOURCE0[k*L_DATA_W +: L_DATA_W];
                w_s1        = iENTRY_SOURCE1[k*L_DATA_W +: L_DATA_W];
                w_pc        = iENTRY_PC[k*L_DATA_W +: L_DATA_W];
                w_dst       = iENTRY_DESTINATION_REGNAME[k*L_REG_W +: L_REG_W];
                w_tag       = iENTRY_COMMIT_TAG[k*L_REG_W +: L_REG_W];
            end
        end
    end

    // A held op blocks the register only while the ALU is locked; flush and reset suppress issue.
    assign w_accept     = !r_valid || !iALU_LOCK;
    assign w_issue      = w_found && w_accept && !iREMOVE_VALID && inRESET;
    assign oEXOUT_VALID = w_issue ? w_onehot : '0;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_sys_ldst <= 1'b0;
            r_ldst     <= 1'b0;
            r_s0_sys   <= 1'b0;
            r_s1_sys   <= 1'b0;
            r_dst_sys  <= 1'b0;
            r_s0       <= '0;
            r_s1       <= '0;
            r_pc       <= '0;
            r_dst      <= '0;
            r_tag      <= '0;
            r_ptr      <= '0;
        end else if (iREMOVE_VALID) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_issue) begin
            r_valid    <= 1'b1;
            r_cmd      <= w_cmd;
            r_sys_ldst <= w_sys_ldst;
            r_ldst     <= w_ldst;
            r_s0_sys   <= w_s0_sys;
            r_s1_sys   <= w_s1_sys;
            r_dst_sys  <= w_dst_sys;
            r_s0       <= w_s0;
            r_s1       <= w_s1;
            r_pc       <= w_pc;
            r_dst      <= w_dst;
            r_tag      <= w_tag;
            r_ptr      <= r_ptr + L_PTR_W'(1);
        end else if (w_accept) begin
            r_valid <= 1'b0;
        end
    end

    assign oALU_VALID               = r_valid;
    assign oALU_CMD                 = r_cmd;
    assign oALU_SYS_LDST            = r_sys_ldst;
    assign oALU_LDST                = r_ldst;
    assign oALU_SOURCE0_SYSREG      = r_s0_sys;
    assign oALU_SOURCE0             = r_s0;
    assign oALU_SOURCE1_SYSREG      = r_s1_sys;
    assign oALU_SOURCE1             = r_s1;
    assign oALU_DESTINATION_REGNAME = r_dst;
    assign oALU_DESTINATION_SYSREG  = r_dst_sys;
    assign oALU_COMMIT_TAG          = r_tag;
    assign oALU_PC                  = r_pc;
    assign oEX_EXECUTION_POINTER    = r_ptr;

endmodule

// File: tb/tb_reservation_alu3_issue.sv
// Scoreboard bench for reservation_alu3_issue: stimulus pushes expected issued ops,
// a monitor pops and compares each newly captured ALU op.
module tb_reservation_alu3_issue;
    localparam int N = 4;

    logic            iCLOCK = 1'b0;
    logic            inRESET;
    logic            iREMOVE_VALID;
    logic [N-1:0]    iENTRY_MATCHING;
    logic [5*N-1:0]  iENTRY_CMD;
    logic [N-1:0]    iENTRY_SYS_LDST, iENTRY_LDST;
    logic [N-1:0]    iENTRY_SOURCE0_SYSREG, iENTRY_SOURCE1_SYSREG, iENTRY_DESTINATION_SYSREG;
    logic [32*N-1:0] iENTRY_SOURCE0, iENTRY_SOURCE1, iENTRY_PC;
    logic [6*N-1:0]  iENTRY_DESTINATION_REGNAME, iENTRY_COMMIT_TAG;
    logic [N-1:0]    oEXOUT_VALID;
    logic [3:0]      oEX_EXECUTION_POINTER;
    logic            iALU_LOCK;
    logic            oALU_VALID;
    logic [4:0]      oALU_CMD;
    logic            oALU_SYS_LDST, oALU_LDST, oALU_SOURCE0_SYSREG, oALU_SOURCE1_SYSREG;
    logic            oALU_DESTINATION_SYSREG;
    logic [31:0]     oALU_SOURCE0, oALU_SOURCE1, oALU_PC;
    logic [5:0]      oALU_DESTINATION_REGNAME, oALU_COMMIT_TAG;

    reservation_alu3_issue #(.P_ENTRY_N(N)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iREMOVE_VALID(iREMOVE_VALID),
        .iENTRY_MATCHING(iENTRY_MATCHING), .iENTRY_CMD(iENTRY_CMD),
        .iENTRY_SYS_LDST(iENTRY_SYS_LDST), .iENTRY_LDST(iENTRY_LDST),
        .iENTRY_SOURCE0_SYSREG(iENTRY_SOURCE0_SYSREG), .iENTRY_SOURCE0(iENTRY_SOURCE0),
        .iENTRY_SOURCE1_SYSREG(iENTRY_SOURCE1_SYSREG), .iENTRY_SOURCE1(iENTRY_SOURCE1),
        .iENTRY_DESTINATION_REGNAME(iENTRY_DESTINATION_REGNAME),
        .iENTRY_DESTINATION_SYSREG(iENTRY_DESTINATION_SYSREG),
        .iENTRY_COMMIT_TAG(iENTRY_COMMIT_TAG), .iENTRY_PC(iENTRY_PC),
        .oEXOUT_VALID(oEXOUT_VALID), .oEX_EXECUTION_POINTER(oEX_EXECUTION_POINTER),
        .iALU_LOCK(iALU_LOCK), .oALU_VALID(oALU_VALID), .oALU_CMD(oALU_CMD),
        .oALU_SYS_LDST(oALU_SYS_LDST), .oALU_LDST(oALU_LDST),
        .oALU_SOURCE0_SYSREG(oALU_SOURCE0_SYSREG), .oALU_SOURCE0(oALU_SOURCE0),
        .oALU_SOURCE1_SYSREG(oALU_SOURCE1_SYSREG), .oALU_SOURCE1(oALU_SOURCE1),
        .oALU_DESTINATION_REGNAME(oALU_DESTINATION_REGNAME),
        .oALU_DESTINATION_SYSREG(oALU_DESTINATION_SYSREG),
        .oALU_COMMIT_TAG(oALU_COMMIT_TAG), .oALU_PC(oALU_PC)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        logic [4:0]  cmd;
        logic [4:0]  flags;
        logic [31:0] s0, s1, pc;
        logic [5:0]  dst, tag;
        logic [3:0]  ptr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic m_acc = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Hand-written entry contents: cmd=k+1, src0=0x0F+k, src1=0xA0000000|k<<8,
    // dest=10+k, tag=20+k, pc=0x1000+4k; flags {sys_ldst,ldst,s0sys,s1sys,dsys}.
    function automatic exp_t ent(input int k, input logic [3:0] p);
        exp_t e;
        logic [4:0] fl [4] = '{5'b00100, 5'b10000, 5'b00010, 5'b01001};
        e.cmd   = 5'(k + 1);
        e.flags = fl[k];
        e.s0    = 32'h0000_000F + 32'(k);
        e.s1    = 32'hA000_0000 | (32'(k) << 8);
        e.dst   = 6'(10 + k);
        e.tag   = 6'(20 + k);
        e.pc    = 32'h1000 + 32'(4 * k);
        e.ptr   = p;
        return e;
    endfunction

    task automatic step();
        @(posedge iCLOCK);
        @(negedge iCLOCK);
    endtask

    // Monitor: a new op is present when the previous edge could accept and was not a flush.
    always @(posedge iCLOCK) m_acc <= inRESET && (!oALU_VALID || !iALU_LOCK) && !iREMOVE_VALID;

    always @(negedge iCLOCK) begin
        if (inRESET && m_acc && oALU_VALID) begin
            if (q.size() == 0) begin
                chk("unexpected_op", {59'd0, oALU_CMD}, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("alu_cmd", 64'(oALU_CMD), 64'(e.cmd));
                chk("alu_flags", 64'({oALU_SYS_LDST, oALU_LDST, oALU_SOURCE0_SYSREG,
                                      oALU_SOURCE1_SYSREG, oALU_DESTINATION_SYSREG}), 64'(e.flags));
                chk("alu_src", {oALU_SOURCE0, oALU_SOURCE1}, {e.s0, e.s1});
                chk("alu_dst_tag", 64'({oALU_DESTINATION_REGNAME, oALU_COMMIT_TAG}), 64'({e.dst, e.tag}));
                chk("alu_pc", 64'(oALU_PC), 64'(e.pc));
                chk("alu_ptr", 64'(oEX_EXECUTION_POINTER), 64'(e.ptr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        inRESET = 1'b0; iREMOVE_VALID = 1'b0; iALU_LOCK = 1'b0; iENTRY_MATCHING = '0;
        iENTRY_SYS_LDST = 4'b0010; iENTRY_LDST = 4'b1000;
        iENTRY_SOURCE0_SYSREG = 4'b0001; iENTRY_SOURCE1_SYSREG = 4'b0100;
        iENTRY_DESTINATION_SYSREG = 4'b1000;
        for (int k = 0; k < N; k++) begin
            e = ent(k, 4'h0);
            iENTRY_CMD[k*5 +: 5]                 = e.cmd;
            iENTRY_SOURCE0[k*32 +: 32]           = e.s0;
            iENTRY_SOURCE1[k*32 +: 32]           = e.s1;
            iENTRY_PC[k*32 +: 32]                = e.pc;
            iENTRY_DESTINATION_REGNAME[k*6 +: 6] = e.dst;
            iENTRY_COMMIT_TAG[k*6 +: 6]          = e.tag;
        end
        repeat (2) step();
        chk("rst_valid", 64'(oALU_VALID), 64'd0);
        chk("rst_ptr", 64'(oEX_EXECUTION_POINTER), 64'd0);
        inRESET = 1'b1;
        step();

        // Single issue from entry 2.
        iENTRY_MATCHING = 4'b0100;
        #1 chk("t2_exout", 64'(oEXOUT_VALID), 64'b0100);
        q.push_back(ent(2, 4'd1));
        step();
        iENTRY_MATCHING = 4'b0000;
        chk("t2_valid", 64'(oALU_VALID), 64'd1);
        chk("t2_cmd", 64'(oALU_CMD), 64'h03);
        chk("t2_src0", 64'(oALU_SOURCE0), 64'h11);
        chk("t2_ptr", 64'(oEX_EXECUTION_POINTER), 64'd1);

        // Priority: entry 1 before entry 3, back to back.
        iENTRY_MATCHING = 4'b1010;
        #1 chk("t3_exout_a", 64'(oEXOUT_VALID), 64'b0010);
        q.push_back(ent(1, 4'd2));
        step();
        iENTRY_MATCHING = 4'b1000;
        #1 chk("t3_exout_b", 64'(oEXOUT_VALID), 64'b1000);
        q.push_back(ent(3, 4'd3));
        step();
        iENTRY_MATCHING = 4'b0000;
        chk("t3_ptr", 64'(oEX_EXECUTION_POINTER), 64'd3);
        step();
        chk("t3_idle_valid", 64'(oALU_VALID), 64'd0);

        // Lock holds the captured op and blocks issue.
        iENTRY_MATCHING = 4'b0001;
        q.push_back(ent(0, 4'd4));
        step();
        iALU_LOCK = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_lock_exout", 64'(oEXOUT_VALID), 64'd0);
            step();
            chk("t4_hold", {oALU_PC, 23'd0, oALU_VALID, oALU_CMD, oEX_EXECUTION_POINTER},
                {32'h1000, 23'd0, 1'b1, 5'h01, 4'd4});
        end
        iALU_LOCK = 1'b0;
        #1 chk("t4_release_exout", 64'(oEXOUT_VALID), 64'b0001);
        q.push_back(ent(0, 4'd5));
        step();
        iENTRY_MATCHING = 4'b0000;
        step();

        // Pointer wrap 4'hF -> 4'h0.
        iENTRY_MATCHING = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            q.push_back(ent(2, 4'(6 + i)));
            step();
        end
        iENTRY_MATCHING = 4'b0000;
        step();
        chk("t5_ptr_f", 64'(oEX_EXECUTION_POINTER), 64'hF);
        iENTRY_MATCHING = 4'b1000;
        q.push_back(ent(3, 4'h0));
        step();
        iENTRY_MATCHING = 4'b0000;
        chk("t5_ptr_wrap", 64'(oEX_EXECUTION_POINTER), 64'h0);
        step();

        // Flush while locked with a ready entry.
        iENTRY_MATCHING = 4'b0010;
        q.push_back(ent(1, 4'd1));
        step();
        iALU_LOCK = 1'b1; iREMOVE_VALID = 1'b1; iENTRY_MATCHING = 4'b0001;
        #1 chk("t6_flush_exout", 64'(oEXOUT_VALID), 64'd0);
        step();
        chk("t6_valid", 64'(oALU_VALID), 64'd0);
        chk("t6_ptr", 64'(oEX_EXECUTION_POINTER), 64'd0);
        iREMOVE_VALID = 1'b0; iALU_LOCK = 1'b0; iENTRY_MATCHING = 4'b0000;
        step();

        // Async reset mid-run while an op is held.
        iENTRY_MATCHING = 4'b1000;
        q.push_back(ent(3, 4'd1));
        step();
        iENTRY_MATCHING = 4'b0001;
        chk("t1_pre_valid", 64'(oALU_VALID), 64'd1);
        #2 inRESET = 1'b0;
        #1;
        chk("t1_rst_valid", 64'(oALU_VALID), 64'd0);
        chk("t1_rst_data", {oALU_SOURCE0, oALU_PC}, 64'd0);
        chk("t1_rst_misc", 64'({oALU_CMD, oALU_DESTINATION_REGNAME, oALU_COMMIT_TAG,
                                oEX_EXECUTION_POINTER, oEXOUT_VALID}), 64'd0);
        @(negedge iCLOCK);
        inRESET = 1'b1; iENTRY_MATCHING = 4'b0000;
        step();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
